// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-style control FSM with retired-instruction counter
module multicycle_ctrl #(
    parameter int CNT_W        = 32,
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             iord,
    output logic             alu_src_a,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12,
        S_ERROR  = 4'd13
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic [5:0]       w_opcode;
    logic             w_retire;
    logic             w_pc_en;
    logic             w_ir_write;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_reg_write;

    assign w_opcode = inst[31:26];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_pc_en     = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        iord        = 1'b0;
        alu_src_a   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_source   = 2'b00;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = mem_ready;
                w_pc_en    = mem_ready;
                if (mem_ready)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                // An all-zero word halts before the opcode is even looked at.
                if (HALT_ON_ZERO && inst == 32'h0)
                    w_next = S_HALT;
                else begin
                    case (w_opcode)
                        6'h00:        w_next = S_EXEC;
                        6'h23, 6'h2B: w_next = S_MEMADR;
                        6'h04:        w_next = S_BRANCH;
                        6'h02:        w_next = S_JUMP;
                        6'h08:        w_next = S_ADDIEX;
                        default:      w_next = S_ERROR;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (w_opcode == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                iord       = 1'b1;
                if (mem_ready)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                iord        = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_RWB;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                w_pc_en   = zero;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                w_pc_en   = 1'b1;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_HALT:  halted  = 1'b1;
            S_ERROR: illegal = 1'b1;
            default: w_next = S_ERROR;
        endcase
    end

    // Enables are gated by reset so nothing reaches memory or the register file mid-reset.
    assign pc_en     = w_pc_en     & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign mem_read  = w_mem_read  & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign state     = r_state;
    assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      inst = 32'h0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b1;
    logic             pc_en, ir_write, mem_read, mem_write, reg_write;
    logic             iord, alu_src_a, reg_dst, mem_to_reg;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic             halted, illegal;
    logic [CNT_W-1:0] retired;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       z;
    } ent_t;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    multicycle_ctrl #(.CNT_W(CNT_W), .HALT_ON_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .iord(iord), .alu_src_a(alu_src_a), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] enables();
        return {pc_en, ir_write, mem_read, mem_write, reg_write};
    endfunction

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1;
        tick();
        n_checks++; if (state !== 4'd0) $display("FAIL reset_state got %0d exp 0", state); else n_pass++;
        n_checks++; if (retired !== '0) $display("FAIL reset_retired got %0d exp 0", retired); else n_pass++;
        n_checks++; if ({halted, illegal} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {halted, illegal}); else n_pass++;
        n_checks++; if (enables() !== 5'b0) $display("FAIL reset_enables got %b exp 00000", enables()); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        ent_t e;
        logic [CNT_W-1:0] r0 = retired;
        inst = 32'h012A5820;
        sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
        sb.push_back('{4'd6, 1'b1, 1'b0}); sb.push_back('{4'd7, 1'b1, 1'b0});
        sb.push_back('{4'd0, 1'b1, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); mem_ready = e.mr; zero = e.z; #1;
            n_checks++; if (state !== e.st) $display("FAIL rtype_state got %0d exp %0d", state, e.st); else n_pass++;
            n_checks++; if (reg_write !== (e.st == 4'd7)) $display("FAIL rtype_reg_write st %0d got %b", e.st, reg_write); else n_pass++;
            if (e.st == 4'd7) begin
                n_checks++; if (reg_dst !== 1'b1) $display("FAIL rtype_reg_dst got %b exp 1", reg_dst); else n_pass++;
            end
            if (sb.size() > 0) tick();
        end
        n_checks++; if (retired !== r0 + 1'b1) $display("FAIL rtype_retired got %0d exp %0d", retired, r0 + 1'b1); else n_pass++;
    endtask

    task automatic test_lw_wait();
        ent_t e;
        int cyc = 0;
        logic [CNT_W-1:0] r0 = retired;
        inst = 32'h8D0B0000;
        sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
        sb.push_back('{4'd2, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) sb.push_back('{4'd3, 1'b0, 1'b0});
        sb.push_back('{4'd3, 1'b1, 1'b0}); sb.push_back('{4'd4, 1'b1, 1'b0});
        sb.push_back('{4'd0, 1'b1, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); mem_ready = e.mr; zero = e.z; #1;
            n_checks++; if (state !== e.st) $display("FAIL lw_state got %0d exp %0d", state, e.st); else n_pass++;
            if (e.st == 4'd3) begin
                n_checks++; if ({mem_read, iord} !== 2'b11) $display("FAIL lw_memrd_ctl got %b exp 11", {mem_read, iord}); else n_pass++;
            end
            if (e.st == 4'd4) begin
                n_checks++; if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) $display("FAIL lw_memwb_ctl got %b exp 110", {reg_write, mem_to_reg, reg_dst}); else n_pass++;
            end
            if (sb.size() > 0) begin tick(); cyc++; end
        end
        n_checks++; if (cyc !== 8) $display("FAIL lw_cycles got %0d exp 8", cyc); else n_pass++;
        n_checks++; if (retired !== r0 + 1'b1) $display("FAIL lw_retired got %0d exp %0d", retired, r0 + 1'b1); else n_pass++;
        mem_ready = 1'b1;
    endtask

    task automatic test_beq();
        ent_t e;
        logic [CNT_W-1:0] r0 = retired;
        inst = 32'h11090002;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{4'd0, 1'b1, k == 0}); sb.push_back('{4'd1, 1'b1, k == 0});
            sb.push_back('{4'd8, 1'b1, k == 0});
        end
        sb.push_back('{4'd0, 1'b1, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); mem_ready = e.mr; zero = e.z; #1;
            n_checks++; if (state !== e.st) $display("FAIL beq_state got %0d exp %0d", state, e.st); else n_pass++;
            if (e.st == 4'd8) begin
                n_checks++; if (pc_en !== e.z) $display("FAIL beq_pc_en got %b exp %b", pc_en, e.z); else n_pass++;
                n_checks++; if (pc_source !== 2'b01) $display("FAIL beq_pc_source got %b exp 01", pc_source); else n_pass++;
            end
            if (sb.size() > 0) tick();
        end
        n_checks++; if (retired !== r0 + 2'd2) $display("FAIL beq_retired got %0d exp %0d", retired, r0 + 2'd2); else n_pass++;
        zero = 1'b0;
    endtask

    task automatic test_addi_sw();
        ent_t e;
        logic [CNT_W-1:0] r0 = retired;
        inst = 32'h2109000A;
        sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
        sb.push_back('{4'd10, 1'b1, 1'b0}); sb.push_back('{4'd11, 1'b1, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); #1;
            n_checks++; if (state !== e.st) $display("FAIL addi_state got %0d exp %0d", state, e.st); else n_pass++;
            if (e.st == 4'd11) begin
                n_checks++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) $display("FAIL addi_wb_ctl got %b exp 100", {reg_write, reg_dst, mem_to_reg}); else n_pass++;
            end
            tick();
        end
        inst = 32'hAD0B0004;
        sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
        sb.push_back('{4'd2, 1'b1, 1'b0}); sb.push_back('{4'd5, 1'b1, 1'b0});
        sb.push_back('{4'd0, 1'b1, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); #1;
            n_checks++; if (state !== e.st) $display("FAIL sw_state got %0d exp %0d", state, e.st); else n_pass++;
            if (e.st == 4'd5) begin
                n_checks++; if ({mem_write, iord, mem_read} !== 3'b110) $display("FAIL sw_ctl got %b exp 110", {mem_write, iord, mem_read}); else n_pass++;
            end
            if (sb.size() > 0) tick();
        end
        n_checks++; if (retired !== r0 + 2'd2) $display("FAIL addi_sw_retired got %0d exp %0d", retired, r0 + 2'd2); else n_pass++;
    endtask

    task automatic test_halt();
        ent_t e;
        logic [CNT_W-1:0] r0 = retired;
        inst = 32'h0;
        sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
        sb.push_back('{4'd12, 1'b1, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); #1;
            n_checks++; if (state !== e.st) $display("FAIL halt_state got %0d exp %0d", state, e.st); else n_pass++;
            if (sb.size() > 0) tick();
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++; if ({state, halted, enables()} !== {4'd12, 1'b1, 5'b0}) $display("FAIL halt_hold cyc %0d st %0d halted %b en %b", i, state, halted, enables()); else n_pass++;
            tick();
        end
        n_checks++; if (retired !== r0) $display("FAIL halt_retired got %0d exp %0d", retired, r0); else n_pass++;
        reset = 1'b1; tick(); reset = 1'b0; #1;
        n_checks++; if ({state, halted} !== {4'd0, 1'b0}) $display("FAIL halt_resume st %0d halted %b exp 0 0", state, halted); else n_pass++;
    endtask

    task automatic test_error_and_reset_midwait();
        ent_t e;
        inst = 32'hFC000000;
        sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
        sb.push_back('{4'd13, 1'b1, 1'b0}); sb.push_back('{4'd13, 1'b1, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); #1;
            n_checks++; if (state !== e.st) $display("FAIL err_state got %0d exp %0d", state, e.st); else n_pass++;
            if (e.st == 4'd13) begin
                n_checks++; if ({illegal, enables()} !== 6'b100000) $display("FAIL err_flags got %b exp 100000", {illegal, enables()}); else n_pass++;
            end
            if (sb.size() > 0) tick();
        end
        reset = 1'b1; tick(); reset = 1'b0; #1;
        n_checks++; if ({state, illegal} !== {4'd0, 1'b0}) $display("FAIL err_resume st %0d illegal %b exp 0 0", state, illegal); else n_pass++;
        inst = 32'h08000000;
        tick(); tick(); tick();
        n_checks++; if (retired !== 4'd1) $display("FAIL err_j_retired got %0d exp 1", retired); else n_pass++;
        inst = 32'hAD0B0004;
        sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
        sb.push_back('{4'd2, 1'b1, 1'b0}); sb.push_back('{4'd5, 1'b0, 1'b0});
        sb.push_back('{4'd5, 1'b0, 1'b0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); mem_ready = e.mr; #1;
            n_checks++; if (state !== e.st) $display("FAIL swwait_state got %0d exp %0d", state, e.st); else n_pass++;
            if (e.st == 4'd5) begin
                n_checks++; if (mem_write !== 1'b1) $display("FAIL swwait_mem_write got %b exp 1", mem_write); else n_pass++;
            end
            if (sb.size() > 0) tick();
        end
        reset = 1'b1; #1;
        n_checks++; if (mem_write !== 1'b0) $display("FAIL swwait_reset_gate got %b exp 0", mem_write); else n_pass++;
        tick(); reset = 1'b0; mem_ready = 1'b1; #1;
        n_checks++; if ({state, retired} !== {4'd0, 4'd0}) $display("FAIL swwait_reset st %0d retired %0d exp 0 0", state, retired); else n_pass++;
    endtask

    task automatic test_wrap();
        ent_t e;
        inst = 32'h08000000;
        for (int k = 0; k < 16; k++) begin
            sb.push_back('{4'd0, 1'b1, 1'b0}); sb.push_back('{4'd1, 1'b1, 1'b0});
            sb.push_back('{4'd9, 1'b1, 1'b0});
        end
        sb.push_back('{4'd0, 1'b1, 1'b0});
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); #1;
            n_checks++; if (state !== e.st) $display("FAIL wrap_state got %0d exp %0d", state, e.st); else n_pass++;
            if (e.st == 4'd9 && k == 2) begin
                n_checks++; if ({pc_en, pc_source} !== 3'b110) $display("FAIL jump_ctl got %b exp 110", {pc_en, pc_source}); else n_pass++;
            end
            if (k == 45) begin
                n_checks++; if (retired !== 4'd15) $display("FAIL wrap_preload got %0d exp 15", retired); else n_pass++;
            end
            if (sb.size() > 0) tick();
        end
        n_checks++; if (retired !== 4'd0) $display("FAIL wrap_retired got %0d exp 0", retired); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_addi_sw();
        test_halt();
        test_error_and_reset_midwait();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter HALT_ON_ZERO, default 1: when 1, an all-zero instruction word halts the machine; when 0, it is executed as R-type.
REQ-003 clk  input  1: single clock; all state updates occur on the rising edge.
REQ-004 reset  input  1: synchronous, active-high.
REQ-005 inst  input  32: instruction register contents (opcode = inst[31:26]).
REQ-006 zero  input  1: ALU zero flag.
REQ-007 mem_ready  input  1: memory has completed the current access this cycle.
REQ-008 pc_en, ir_write, mem_read, mem_write, reg_write  output  1 each: datapath enables.
REQ-009 iord, alu_src_a, reg_dst, mem_to_reg  output  1 each: mux selects.
REQ-010 alu_src_b  output  2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2); alu_op  output  2 (00 add, 01 sub, 10 funct-decoded); pc_source  output  2 (00 ALU result, 01 ALUOut, 10 jump target).
REQ-011 state  output  4: current state; halted, illegal  output  1 each; retired  output  CNT_W: count of completed instructions.

Function
REQ-012 States SHALL be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12, ERROR=13; codes 14-15 SHALL transition to ERROR.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_en=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 0x00 -> EXEC, 0x23/0x2B -> MEMADR, 0x04 -> BRANCH, 0x02 -> JUMP, 0x08 -> ADDIEX, any other -> ERROR.
REQ-015 DECODE with inst==32'h0 and HALT_ON_ZERO=1 SHALL go to HALT, taking priority over opcode decode.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next is MEMRD for 0x23, MEMWR for 0x2B.
REQ-017 MEMRD: mem_read=1, iord=1; hold while mem_ready=0; then MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-018 MEMWR: mem_write=1, iord=1; hold while mem_ready=0; then FETCH; mem_write SHALL stay asserted for every wait cycle.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero; then FETCH.
REQ-021 JUMP: pc_source=10, pc_en=1; then FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-023 HALT: halted=1, all enables 0, remain until reset. ERROR: illegal=1, all enables 0, remain until reset.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 retired SHALL increment by 1 on each edge that moves from MEMWB, MEMWR (with mem_ready=1), RWB, BRANCH, JUMP or ADDIWB to FETCH; it SHALL wrap modulo 2^CNT_W and SHALL NOT increment on entering HALT or ERROR.
REQ-026 Latency with mem_ready always 1: R-type/addi/sw 4 cycles; lw 5 cycles; beq/j 3 cycles.

Reset
REQ-027 On a rising edge with reset=1: state=FETCH, retired=0, halted=0, illegal=0.
REQ-028 While reset=1, pc_en, ir_write, mem_read, mem_write and reg_write SHALL be forced to 0 combinationally, including when reset arrives mid-instruction or during a memory wait.
REQ-029 Reset from HALT or ERROR SHALL resume at FETCH on the next edge.

Verification
REQ-030 Apply R-type add (0x012A5820) with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in state 7 with reg_dst=1; retired 0 -> 1.
REQ-031 Apply lw (0x8D0B0000) with mem_ready=0 for 3 cycles in MEMRD -> state 3 held 4 cycles with mem_read=iord=1, then 4, then 0; total 8 cycles; retired +1.
REQ-032 Apply beq (0x11090002) with zero=1 and then zero=0 -> pc_en=1 in BRANCH the first time, 0 the second; pc_source=01 both times; retired +2.
REQ-033 Apply inst=0x00000000 -> FETCH, DECODE, HALT; halted=1 held 20 cycles with all enables 0; retired unchanged.
REQ-034 Apply opcode 0x3F -> ERROR, illegal=1; assert reset during MEMWR wait of a later sw (0xAD0B0004) -> mem_write=0 the same cycle, state=0 next edge, retired=0.
REQ-035 Preload retired to 2^CNT_W-1 via 2^CNT_W-1 j instructions (CNT_W=4: 15) -> one more j yields retired=0.
